bcd_cascade_counter: RTL and testbench
======================================

// Module: bcd_cascade_counter
// PURPOSE
//  Registered multi-digit BCD up/down counter built by chaining one-digit steps. Each digit consumes the
//  lower digit's carry/borrow (cout) as its enable. Sits behind the single-digit BCD step logic.
//  Drives display/timer datapaths and emits a terminal-count pulse for further cascading.
// PARAMETERS
//  DIGITS   2   number of BCD digits (count width = 4*DIGITS)
// PORTS
//  clk       in   1          rising-edge clock
//  rst_n     in   1          asynchronous active-low reset
//  en        in   1          count enable for this cycle
//  dir       in   1          1 = up, 0 = down
//  load      in   1          synchronous load of load_val
//  load_val  in   4*DIGITS   BCD value to load; digit i = bits [4i+3:4i]
//  count     out  4*DIGITS   current BCD count, registered
//  cout      out  1          registered terminal pulse (carry on up-wrap, borrow on down-wrap)
// BEHAVIOUR
//  - Reset (rst_n=0, async): count=0, cout=0 immediately. Hold while low.
//  - Priority per rising edge: load > en > hold.
//  - load=1: count <= load_val with any digit >9 replaced by 0; cout <= 0; en and dir are ignored.
//  - en=0, load=0: count holds; cout <= 0.
//  - en=1, up: digit0 steps +1. Digit i steps when every lower digit is 9 (ripple of digit carries).
//    A digit stepping from 9 goes to 0. A digit >9 (cannot occur after load sanitising) steps to 0 with no carry.
//  - en=1, down: digit0 steps -1. Digit i steps when every lower digit is 0.
//    A digit stepping from 0 goes to 9.
//  - Terminal wrap: up from all-9 -> all-0 with cout=1; down from all-0 -> all-9 with cout=1.
//    cout is 1 for exactly that cycle.
//  - Latency: count and cout both update on the same edge that samples en. No combinational path from inputs to outputs.
//  - dir may change every cycle. Each edge uses the dir sampled at that edge.
//  - Reset asserted mid-count aborts and clears. First edge after release behaves as from count=0.
// CONFIGURATION
//  BCD_CNT_SATURATE_EN defined:
//    - Up at all-9 holds all-9; down at all-0 holds all-0.
//    - cout=1 for each cycle en=1 at the terminal value. No wrap.
//  Undefined: wrap-around as above.
//  Load and reset behaviour are identical in both builds.
// STRUCTURE
//  Shared package bcd_pkg:
//    - BCD_MAX=4'd9, BCD_MIN=4'd0
//    - bcd_digit_t (4-bit) typedef
//    - function bcd_sanitize (>9 -> 0)
//  Sub-module bcd_digit_step: combinational one-digit step.
//    - inputs d[3:0], dir, step_en; outputs q[3:0], c_out.
//    - c_out=1 only on a 9->0 (up) or 0->9 (down) step.
//    - Invalid d with step_en -> q=0, c_out=0.
//  Instantiated DIGITS times via generate. Carry chain: step_en[i+1] = step_en[i] & c_out[i].
//  Top register bank plus cout flop.
// TESTING (DIGITS=2)
//  1. Reset: rst_n low mid-run with count=47 -> count=00, cout=0 without waiting for clk.
//  2. Up: load 08, en=1 dir=1 for 3 cycles -> 09,10,11, cout=0 throughout.
//     Load 98, 2 cycles -> 99, then 00 with cout=1 for one cycle (saturate build: 99, 99, cout=1).
//  3. Down: load 11, en=1 dir=0 -> 10,09. Load 00, 1 cycle -> 99 with cout=1 (saturate build: 00, cout=1).
//  4. Load sanitise: load_val=8'hA5 with en=1 -> count=05, cout=0. load_val=8'h3F -> 30.
//  5. Priority/hold: load=1 with en=1 -> loaded value, not stepped. en=0 for 5 cycles -> count unchanged, cout=0.
//  6. Dir toggle: from 50, dir alternates 1,0,1 with en=1 -> 51,50,51. Sweep 00->99->00 up, then back down, vs model.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and load sanitising helper.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;
   localparam bcd_digit_t BCD_MIN = 4'd0;

   // Non-decimal nibbles collapse to zero so the counter only ever holds valid BCD.
   function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
      return (d > BCD_MAX) ? BCD_MIN : d;
   endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Combinational single-digit BCD step; c_out flags a 9->0 (up) or 0->9 (down) wrap.
module bcd_digit_step
   import bcd_pkg::*;
(
   input  bcd_digit_t d,
   input  logic       dir,
   input  logic       step_en,
   output bcd_digit_t q,
   output logic       c_out
);

   always_comb begin
      q     = d;
      c_out = 1'b0;
      if (step_en) begin
         if (d > BCD_MAX) begin
            q = BCD_MIN;
         end else if (dir) begin
            if (d == BCD_MAX) begin
               q     = BCD_MIN;
               c_out = 1'b1;
            end else begin
               q = d + 4'd1;
            end
         end else begin
            if (d == BCD_MIN) begin
               q     = BCD_MAX;
               c_out = 1'b1;
            end else begin
               q = d - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/bcd_cascade_counter.sv
// Registered multi-digit BCD up/down counter with terminal-count pulse.
// Define BCD_CNT_SATURATE_EN to hold at the terminal value instead of wrapping.
module bcd_cascade_counter
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 2
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  dir,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count,
   output logic                  cout
);

   logic [DIGITS:0]     step_en;
   logic [DIGITS-1:0]   carry;
   logic [4*DIGITS-1:0] next_count;

   assign step_en[0] = en;

   // step_en[DIGITS] is the carry out of the top digit, i.e. the terminal wrap.
   genvar i;
   generate
      for (i = 0; i < DIGITS; i++) begin : g_digit
         bcd_digit_step u_step (
            .d       (count[4*i +: 4]),
            .dir     (dir),
            .step_en (step_en[i]),
            .q       (next_count[4*i +: 4]),
            .c_out   (carry[i])
         );
         assign step_en[i+1] = step_en[i] & carry[i];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         cout  <= 1'b0;
      end else if (load) begin
         for (int unsigned k = 0; k < DIGITS; k++) begin
            count[4*k +: 4] <= bcd_sanitize(load_val[4*k +: 4]);
         end
         cout <= 1'b0;
      end else if (en) begin
`ifdef BCD_CNT_SATURATE_EN
         if (!step_en[DIGITS]) begin
            count <= next_count;
         end
         cout <= step_en[DIGITS];
`else
         count <= next_count;
         cout  <= step_en[DIGITS];
`endif
      end else begin
         cout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Scoreboard bench for bcd_cascade_counter (DIGITS=2) against an integer-valued reference model.
module tb_bcd_cascade_counter;

   localparam int DIGITS = 2;
   localparam int W      = 4 * DIGITS;
   localparam int MAXV   = 99;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         en = 1'b0;
   logic         dir = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] count;
   logic         cout;

   bcd_cascade_counter #(.DIGITS(DIGITS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .dir      (dir),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .cout     (cout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] count;
      logic         cout;
      string        tag;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   model_val = 0;

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic int load_value(input logic [W-1:0] lv);
      int v, p, dg;
      v = 0;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         dg = int'(lv[4*i +: 4]);
         if (dg > 9) dg = 0;
         v += dg * p;
         p = p * 10;
      end
      return v;
   endfunction

   task automatic step(input logic l, input logic [W-1:0] lv, input logic e,
                       input logic d, input string tag);
      exp_t x;
      int   nv;
      logic c;
      @(negedge clk);
      load = l; load_val = lv; en = e; dir = d;
      nv = model_val;
      c  = 1'b0;
      if (l) begin
         nv = load_value(lv);
      end else if (e) begin
         if (d) begin
            if (model_val == MAXV) begin
               c = 1'b1;
`ifdef BCD_CNT_SATURATE_EN
               nv = MAXV;
`else
               nv = 0;
`endif
            end else nv = model_val + 1;
         end else begin
            if (model_val == 0) begin
               c = 1'b1;
`ifdef BCD_CNT_SATURATE_EN
               nv = 0;
`else
               nv = MAXV;
`endif
            end else nv = model_val - 1;
         end
      end
      model_val = nv;
      x.count = to_bcd(nv);
      x.cout  = c;
      x.tag   = tag;
      sb.push_back(x);
   endtask

   task automatic reset_mid(input string tag);
      @(negedge clk);
      #2;
      en = 1'b0; load = 1'b0;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (count !== '0 || cout !== 1'b0) begin
         miscompares++;
         $display("FAIL %s: count=%h cout=%b, expected count=00 cout=0", tag, count, cout);
      end
      model_val = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            vectors++;
            if (count !== x.count || cout !== x.cout) begin
               miscompares++;
               $display("FAIL %s: count=%h cout=%b, expected count=%h cout=%b",
                        x.tag, count, cout, x.count, x.cout);
            end
         end
      end
   end

   initial begin
      #2;
      reset_mid("power_on_reset");

      step(1'b1, 8'h47, 1'b0, 1'b0, "load_47");
      step(1'b0, '0,    1'b0, 1'b0, "hold_47");
      reset_mid("async_reset_at_47");
      step(1'b0, '0,    1'b1, 1'b1, "first_after_reset");

      step(1'b1, 8'h08, 1'b0, 1'b1, "load_08");
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1, "up_from_08");
      step(1'b1, 8'h98, 1'b0, 1'b1, "load_98");
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1, "up_wrap_99");

      step(1'b1, 8'h11, 1'b0, 1'b0, "load_11");
      for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0, "down_from_11");
      step(1'b1, 8'h00, 1'b0, 1'b0, "load_00");
      for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0, "down_wrap_00");

      step(1'b1, 8'hA5, 1'b1, 1'b1, "sanitize_A5");
      step(1'b1, 8'h3F, 1'b1, 1'b0, "sanitize_3F");
      step(1'b1, 8'hFF, 1'b1, 1'b1, "sanitize_FF");

      step(1'b1, 8'h62, 1'b1, 1'b1, "load_over_en");
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, i[0], "hold_en0");

      step(1'b1, 8'h50, 1'b0, 1'b0, "load_50");
      step(1'b0, '0, 1'b1, 1'b1, "dir_toggle_up");
      step(1'b0, '0, 1'b1, 1'b0, "dir_toggle_down");
      step(1'b0, '0, 1'b1, 1'b1, "dir_toggle_up2");

      step(1'b1, 8'h00, 1'b0, 1'b1, "sweep_load");
      for (int i = 0; i < 101; i++) step(1'b0, '0, 1'b1, 1'b1, "sweep_up");
      for (int i = 0; i < 101; i++) step(1'b0, '0, 1'b1, 1'b0, "sweep_down");

      for (int i = 0; i < 400; i++) begin
         logic [W-1:0] lv;
         lv = W'($urandom);
         if (i == 200) reset_mid("random_reset");
         step(($urandom_range(0, 15) == 0), lv, ($urandom_range(0, 3) != 0),
              1'($urandom), "random");
      end

      @(negedge clk);
      en = 1'b0; load = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: pending=%0d, expected pending=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
